flit_injector: RTL and testbench
================================

FLIT_INJECTOR -- requirements
Module: flit_injector

Interface
REQ-001 SHALL have parameter MAXVC, default 4, number of virtual channels served.
REQ-002 SHALL have parameter DST_W, default 14, destination router index width.
REQ-003 SHALL have parameter LEN_W, default 4, packet length field width in flits.
REQ-004 SHALL have parameter DEPTH, default 4, descriptor FIFO entries (power of two).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port pkt_valid  input  1  descriptor offered.
REQ-008 SHALL have port pkt_ready  output  1  descriptor accepted when valid&ready.
REQ-009 SHALL have port pkt_dst  input  DST_W  destination.
REQ-010 SHALL have port pkt_vc  input  clog2(MAXVC)  injection VC.
REQ-011 SHALL have port pkt_len  input  LEN_W  flits in packet (0 means 1).
REQ-012 SHALL have port step  input  1  one-cycle pulse marking a network cycle, aligned with router LoadStaging.
REQ-013 SHALL have port can_inject  input  MAXVC  per-VC router port-0 buffer free.
REQ-014 SHALL have port staging  output  BUF_W  injection word to router input port 0: {full, vc, tail, dst, pkt_id, flit_idx}.
REQ-015 SHALL have port idle  output  1  FIFO empty and no packet in flight.
REQ-016 SHALL have ports flit_cnt  output  32, stall_cnt  output  32  statistics (see Configuration).

Function
REQ-017 SHALL store accepted descriptors in a DEPTH-entry FIFO with wrap-around pointers and an explicit count.
REQ-018 SHALL drive pkt_ready = (count != DEPTH) from registered state; a pop in the same cycle does not raise ready.
REQ-019 SHALL implement FSM states IDLE, SEND: IDLE->SEND on rising edge when FIFO non-empty (pop descriptor, flit_idx=0); SEND->IDLE after the tail flit is emitted.
REQ-020 SHALL, on step in SEND with can_inject[vc]=1, register staging with full=1, current vc/dst/pkt_id/flit_idx and tail=1 iff flit_idx==max(len,1)-1, then increment flit_idx.
REQ-021 SHALL, on step in SEND with can_inject[vc]=0, register staging=0 and hold flit_idx (stall).
REQ-022 SHALL, on step in IDLE, register staging=0.
REQ-023 SHALL hold staging unchanged between step pulses.
REQ-024 SHALL never emit flits of two packets interleaved; packets leave in FIFO order.
REQ-025 SHALL assign pkt_id from an 8-bit counter incremented per popped descriptor, wrapping 255->0.
REQ-026 SHALL give minimum latency: descriptor accepted at edge N, first flit registered on first step at edge >= N+2.
REQ-027 SHALL, when SEND emits a tail and FIFO is non-empty, return to IDLE and pop the next descriptor on the following edge (one-step bubble allowed).
REQ-028 SHALL drive idle = (count==0) & (state==IDLE).

Reset
REQ-029 SHALL, while rst_n=0, force staging=0, pkt_ready=0, idle=1, FIFO pointers/count=0, state=IDLE, pkt_id=0, counters=0.
REQ-030 SHALL discard any in-flight packet when reset asserts mid-packet; no tail is emitted.
REQ-031 SHALL release pkt_ready=1 on the first edge after rst_n deasserts.

Configuration
REQ-032 SHALL, with INJ_STATS_EN defined, count flit_cnt per emitted flit and stall_cnt per REQ-021 step, both saturating at 2^32-1.
REQ-033 SHALL, without INJ_STATS_EN, tie flit_cnt and stall_cnt to 0 and instantiate no counter logic.

Structure
REQ-034 SHALL take BUF_W, field offsets, VC width and the staging word layout from shared package noc_pkg.
REQ-035 SHALL contain one sub-module, inj_desc_fifo (descriptor FIFO, count, ready).

Verification
REQ-036 SHALL test: push {dst=5,vc=1,len=3}, can_inject=4'b1111, 3 steps -> flit_idx 0,1,2, tail only on idx 2, full=1, vc=1, dst=5.
REQ-037 SHALL test: len=0 -> single flit with tail=1; len=1 identical.
REQ-038 SHALL test: can_inject[2]=0 for 4 steps on vc=2 packet -> staging=0 for 4 steps, stall_cnt=4 (INJ_STATS_EN), flit_idx resumes at held value.
REQ-039 SHALL test: push 5 descriptors back-to-back with DEPTH=4, no steps -> pkt_ready low after 4th accept, 5th held until a pop.
REQ-040 SHALL test: assert rst_n=0 after 1 of 4 flits -> staging=0, idle=1, next packet starts at flit_idx 0 with pkt_id 0.
REQ-041 SHALL test: 256 single-flit packets -> pkt_id wraps 255->0, flit_cnt=256.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: staging word layout, field offsets and injector FSM states.
package noc_pkg;

  localparam int NOC_MAXVC    = 4;
  localparam int NOC_VC_W     = 2;
  localparam int NOC_DST_W    = 14;
  localparam int NOC_PKT_ID_W = 8;
  localparam int NOC_IDX_W    = 4;

  // Staging word, LSB first: flit_idx, pkt_id, dst, tail, vc, full
  localparam int FLIT_IDX_LSB = 0;
  localparam int PKT_ID_LSB   = FLIT_IDX_LSB + NOC_IDX_W;
  localparam int DST_LSB      = PKT_ID_LSB + NOC_PKT_ID_W;
  localparam int TAIL_BIT     = DST_LSB + NOC_DST_W;
  localparam int VC_LSB       = TAIL_BIT + 1;
  localparam int FULL_BIT     = VC_LSB + NOC_VC_W;
  localparam int BUF_W        = FULL_BIT + 1;

  typedef struct packed {
    logic                    full;
    logic [NOC_VC_W-1:0]     vc;
    logic                    tail;
    logic [NOC_DST_W-1:0]    dst;
    logic [NOC_PKT_ID_W-1:0] pkt_id;
    logic [NOC_IDX_W-1:0]    flit_idx;
  } staging_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } inj_state_t;

endpackage

// File: rtl/inj_desc_fifo.sv
// Descriptor FIFO with wrap-around pointers, explicit occupancy count and registered ready.
module inj_desc_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_valid,
  input  logic [WIDTH-1:0]            push_data,
  output logic                        push_ready,
  input  logic                        pop,
  output logic [WIDTH-1:0]            pop_data,
  output logic                        empty,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             ready_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push    = push_valid & ready_reg;
  assign do_pop     = pop & (count_reg != '0);
  assign count_next = count_reg + CW'(do_push) - CW'(do_pop);

  // Ready is a register so it is low throughout reset and never follows a same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      ready_reg <= (count_next != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign pop_data   = mem[rd_ptr_reg];
  assign empty      = (count_reg == '0);
  assign count      = count_reg;
  assign push_ready = ready_reg;

endmodule

// File: rtl/flit_injector.sv
// Turns packet descriptors into per-step flits on router input port 0.
// Define INJ_STATS_EN to enable saturating flit/stall statistics counters.
module flit_injector
  import noc_pkg::*;
#(
  parameter int MAXVC = 4,
  parameter int DST_W = 14,
  parameter int LEN_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     pkt_valid,
  output logic                                     pkt_ready,
  input  logic [DST_W-1:0]                         pkt_dst,
  input  logic [((MAXVC > 1) ? $clog2(MAXVC) : 1)-1:0] pkt_vc,
  input  logic [LEN_W-1:0]                         pkt_len,
  input  logic                                     step,
  input  logic [MAXVC-1:0]                         can_inject,
  output logic [BUF_W-1:0]                         staging,
  output logic                                     idle,
  output logic [31:0]                              flit_cnt,
  output logic [31:0]                              stall_cnt
);

  localparam int VC_W   = (MAXVC > 1) ? $clog2(MAXVC) : 1;
  localparam int DESC_W = DST_W + VC_W + LEN_W;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              fifo_pop;
  logic [DESC_W-1:0] fifo_data;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  logic [DST_W-1:0]  d_dst;
  logic [VC_W-1:0]   d_vc;
  logic [LEN_W-1:0]  d_len;

  inj_state_t              state_reg;
  logic [DST_W-1:0]        cur_dst_reg;
  logic [VC_W-1:0]         cur_vc_reg;
  logic [LEN_W-1:0]        last_idx_reg;
  logic [LEN_W-1:0]        flit_idx_reg;
  logic [NOC_PKT_ID_W-1:0] cur_pkt_id_reg;
  logic [NOC_PKT_ID_W-1:0] pkt_id_cnt_reg;
  staging_t                staging_reg;
  staging_t                flit_word;
  logic                    is_tail;
  logic                    emit_flit;

  inj_desc_fifo #(
    .WIDTH (DESC_W),
    .DEPTH (DEPTH)
  ) u_desc_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (pkt_valid),
    .push_data  ({pkt_dst, pkt_vc, pkt_len}),
    .push_ready (pkt_ready),
    .pop        (fifo_pop),
    .pop_data   (fifo_data),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign {d_dst, d_vc, d_len} = fifo_data;

  assign fifo_pop  = (state_reg == ST_IDLE) && !fifo_empty;
  assign is_tail   = (flit_idx_reg == last_idx_reg);
  assign emit_flit = (state_reg == ST_SEND) && step && can_inject[cur_vc_reg];

  always_comb begin
    flit_word          = '0;
    flit_word.full     = 1'b1;
    flit_word.vc       = NOC_VC_W'(cur_vc_reg);
    flit_word.tail     = is_tail;
    flit_word.dst      = NOC_DST_W'(cur_dst_reg);
    flit_word.pkt_id   = cur_pkt_id_reg;
    flit_word.flit_idx = NOC_IDX_W'(flit_idx_reg);
  end

  // Staging only changes on step; between steps it holds the last word for the router.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      cur_dst_reg    <= '0;
      cur_vc_reg     <= '0;
      last_idx_reg   <= '0;
      flit_idx_reg   <= '0;
      cur_pkt_id_reg <= '0;
      pkt_id_cnt_reg <= '0;
      staging_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (step) staging_reg <= '0;
          if (!fifo_empty) begin
            cur_dst_reg    <= d_dst;
            cur_vc_reg     <= d_vc;
            last_idx_reg   <= (d_len == '0) ? '0 : d_len - LEN_W'(1);
            flit_idx_reg   <= '0;
            cur_pkt_id_reg <= pkt_id_cnt_reg;
            pkt_id_cnt_reg <= pkt_id_cnt_reg + NOC_PKT_ID_W'(1);
            state_reg      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (emit_flit) begin
            staging_reg  <= flit_word;
            flit_idx_reg <= flit_idx_reg + LEN_W'(1);
            if (is_tail) state_reg <= ST_IDLE;
          end else if (step) begin
            staging_reg <= '0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign staging = staging_reg;
  assign idle    = (fifo_count == '0) && (state_reg == ST_IDLE);

`ifdef INJ_STATS_EN
  logic [31:0] flit_cnt_reg;
  logic [31:0] stall_cnt_reg;
  logic        stall_step;

  assign stall_step = (state_reg == ST_SEND) && step && !can_inject[cur_vc_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (emit_flit && (flit_cnt_reg != 32'hFFFF_FFFF))
        flit_cnt_reg <= flit_cnt_reg + 32'd1;
      if (stall_step && (stall_cnt_reg != 32'hFFFF_FFFF))
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign flit_cnt  = flit_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
`else
  assign flit_cnt  = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_flit_injector.sv
// Directed self-checking bench for flit_injector (default parameters).
module tb_flit_injector;
  import noc_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pkt_valid;
  logic             pkt_ready;
  logic [13:0]      pkt_dst;
  logic [1:0]       pkt_vc;
  logic [3:0]       pkt_len;
  logic             step;
  logic [3:0]       can_inject;
  logic [BUF_W-1:0] staging;
  logic             idle;
  logic [31:0]      flit_cnt;
  logic [31:0]      stall_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int exp_id  = 0;
  int exp_flits = 0;

`ifdef INJ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  flit_injector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_dst    (pkt_dst),
    .pkt_vc     (pkt_vc),
    .pkt_len    (pkt_len),
    .step       (step),
    .can_inject (can_inject),
    .staging    (staging),
    .idle       (idle),
    .flit_cnt   (flit_cnt),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_step(input logic [3:0] ci);
    can_inject = ci;
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic push(input int dst, input int vc, input int len);
    int n;
    n = 0;
    pkt_valid = 1'b1;
    pkt_dst = 14'(dst);
    pkt_vc  = 2'(vc);
    pkt_len = 4'(len);
    while (!pkt_ready && n < 50) begin
      tick();
      n++;
    end
    n_total++;
    if (n >= 50) begin
      n_bad++;
      $display("FAIL push_timeout: pkt_ready got %0b want 1 within 50 cycles", pkt_ready);
    end
    tick();
    pkt_valid = 1'b0;
    $display("push dst=%0d vc=%0d len=%0d", dst, vc, len);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    exp_id = 0;
    exp_flits = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pkt_valid = 1'b0; pkt_dst = '0; pkt_vc = '0; pkt_len = '0;
    step = 1'b0; can_inject = 4'hF;
    #2;
    n_total++; if (staging !== '0) begin n_bad++; $display("FAIL rst_staging: got %0h want 0", staging); end
    n_total++; if (pkt_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %0b want 0", pkt_ready); end
    n_total++; if (idle !== 1'b1) begin n_bad++; $display("FAIL rst_idle: got %0b want 1", idle); end
    n_total++; if (flit_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_flit_cnt: got %0d want 0", flit_cnt); end
    tick();
    tick();
    rst_n = 1'b1;
    n_total++; if (pkt_ready !== 1'b0) begin n_bad++; $display("FAIL rel_ready_early: got %0b want 0", pkt_ready); end
    tick();
    n_total++; if (pkt_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ready: got %0b want 1", pkt_ready); end
    $display("reset checked");
  endtask

  task automatic test_basic();
    staging_t s;
    push(5, 1, 3);
    do_step(4'hF);
    n_total++; if (staging !== '0) begin n_bad++; $display("FAIL basic_latency: got %0h want 0", staging); end
    for (int i = 0; i < 3; i++) begin
      do_step(4'hF);
      s = staging;
      n_total++;
      if (s.full !== 1'b1 || s.vc !== 2'd1 || s.dst !== 14'd5 || s.flit_idx !== 4'(i)
          || s.tail !== (i == 2) || s.pkt_id !== 8'(exp_id)) begin
        n_bad++;
        $display("FAIL basic_flit%0d: got full=%0b vc=%0d dst=%0d idx=%0d tail=%0b id=%0d want 1 1 5 %0d %0b %0d",
                 i, s.full, s.vc, s.dst, s.flit_idx, s.tail, s.pkt_id, i, (i == 2), exp_id);
      end
      $display("flit pkt=%0d idx=%0d tail=%0b", s.pkt_id, s.flit_idx, s.tail);
    end
    exp_id++; exp_flits += 3;
    s = staging;
    tick();
    n_total++; if (staging !== s) begin n_bad++; $display("FAIL basic_hold: got %0h want %0h", staging, s); end
    n_total++; if (idle !== 1'b1) begin n_bad++; $display("FAIL basic_idle: got %0b want 1", idle); end
  endtask

  task automatic test_len0();
    staging_t s;
    push(7, 0, 0);
    tick();
    do_step(4'hF);
    s = staging;
    n_total++;
    if (s.full !== 1'b1 || s.tail !== 1'b1 || s.flit_idx !== 4'd0 || s.dst !== 14'd7 || s.pkt_id !== 8'(exp_id)) begin
      n_bad++;
      $display("FAIL len0: got full=%0b tail=%0b idx=%0d dst=%0d id=%0d want 1 1 0 7 %0d",
               s.full, s.tail, s.flit_idx, s.dst, s.pkt_id, exp_id);
    end
    exp_id++;
    push(9, 3, 1);
    tick();
    do_step(4'hF);
    s = staging;
    n_total++;
    if (s.full !== 1'b1 || s.tail !== 1'b1 || s.flit_idx !== 4'd0 || s.vc !== 2'd3 || s.dst !== 14'd9 || s.pkt_id !== 8'(exp_id)) begin
      n_bad++;
      $display("FAIL len1: got full=%0b tail=%0b idx=%0d vc=%0d dst=%0d id=%0d want 1 1 0 3 9 %0d",
               s.full, s.tail, s.flit_idx, s.vc, s.dst, s.pkt_id, exp_id);
    end
    exp_id++; exp_flits += 2;
    do_step(4'hF);
    n_total++; if (staging !== '0) begin n_bad++; $display("FAIL idle_step: got %0h want 0", staging); end
  endtask

  task automatic test_stall();
    staging_t s;
    push(3, 2, 3);
    tick();
    do_step(4'hF);
    s = staging;
    n_total++; if (s.full !== 1'b1 || s.flit_idx !== 4'd0 || s.tail !== 1'b0) begin
      n_bad++; $display("FAIL stall_first: got full=%0b idx=%0d tail=%0b want 1 0 0", s.full, s.flit_idx, s.tail); end
    for (int i = 0; i < 4; i++) begin
      do_step(4'b1011);
      n_total++; if (staging !== '0) begin n_bad++; $display("FAIL stall_step%0d: got %0h want 0", i, staging); end
    end
    n_total++; if (stall_cnt !== (STATS ? 32'd4 : 32'd0)) begin
      n_bad++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, STATS ? 4 : 0); end
    for (int i = 1; i < 3; i++) begin
      do_step(4'hF);
      s = staging;
      n_total++;
      if (s.full !== 1'b1 || s.vc !== 2'd2 || s.flit_idx !== 4'(i) || s.tail !== (i == 2) || s.pkt_id !== 8'(exp_id)) begin
        n_bad++;
        $display("FAIL stall_resume%0d: got full=%0b vc=%0d idx=%0d tail=%0b id=%0d want 1 2 %0d %0b %0d",
                 i, s.full, s.vc, s.flit_idx, s.tail, s.pkt_id, i, (i == 2), exp_id);
      end
    end
    exp_id++; exp_flits += 3;
    n_total++; if (flit_cnt !== (STATS ? 32'(exp_flits) : 32'd0)) begin
      n_bad++; $display("FAIL flit_cnt_mid: got %0d want %0d", flit_cnt, STATS ? exp_flits : 0); end
  endtask

  task automatic test_back_to_back();
    staging_t s;
    int n;
    int collected;
    push(1, 0, 15);
    for (int k = 0; k < 4; k++) begin
      pkt_valid = 1'b1; pkt_dst = 14'(10 + k); pkt_vc = 2'd0; pkt_len = 4'd1;
      n_total++; if (pkt_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready%0d: got %0b want 1", k, pkt_ready); end
      tick();
      $display("push dst=%0d vc=0 len=1", 10 + k);
    end
    n_total++; if (pkt_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full: got %0b want 0", pkt_ready); end
    pkt_dst = 14'd14;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++; if (pkt_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_held%0d: got %0b want 0", k, pkt_ready); end
    end
    for (int i = 0; i < 15; i++) begin
      do_step(4'hF);
      s = staging;
      n_total++;
      if (s.full !== 1'b1 || s.flit_idx !== 4'(i) || s.tail !== (i == 14) || s.dst !== 14'd1) begin
        n_bad++;
        $display("FAIL long_flit%0d: got full=%0b idx=%0d tail=%0b dst=%0d want 1 %0d %0b 1",
                 i, s.full, s.flit_idx, s.tail, s.dst, i, (i == 14));
      end
    end
    exp_id++; exp_flits += 15;
    n = 0;
    while (!pkt_ready && n < 5) begin
      tick();
      n++;
    end
    n_total++; if (pkt_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_release: got %0b want 1", pkt_ready); end
    tick();
    pkt_valid = 1'b0;
    $display("push dst=14 vc=0 len=1");
    collected = 0;
    for (int k = 0; k < 40 && collected < 5; k++) begin
      do_step(4'hF);
      s = staging;
      if (s.full) begin
        n_total++;
        if (s.dst !== 14'(10 + collected) || s.pkt_id !== 8'(exp_id) || s.tail !== 1'b1) begin
          n_bad++;
          $display("FAIL order%0d: got dst=%0d id=%0d tail=%0b want %0d %0d 1",
                   collected, s.dst, s.pkt_id, s.tail, 10 + collected, exp_id);
        end
        collected++; exp_id++; exp_flits++;
      end
    end
    n_total++; if (collected != 5) begin n_bad++; $display("FAIL drain_count: got %0d want 5", collected); end
    n_total++; if (flit_cnt !== (STATS ? 32'(exp_flits) : 32'd0)) begin
      n_bad++; $display("FAIL flit_cnt_b2b: got %0d want %0d", flit_cnt, STATS ? exp_flits : 0); end
  endtask

  task automatic test_reset_mid();
    staging_t s;
    push(20, 1, 4);
    tick();
    do_step(4'hF);
    s = staging;
    n_total++; if (s.full !== 1'b1 || s.flit_idx !== 4'd0) begin
      n_bad++; $display("FAIL mid_first: got full=%0b idx=%0d want 1 0", s.full, s.flit_idx); end
    rst_n = 1'b0;
    #1;
    n_total++; if (staging !== '0) begin n_bad++; $display("FAIL mid_staging: got %0h want 0", staging); end
    n_total++; if (idle !== 1'b1) begin n_bad++; $display("FAIL mid_idle: got %0b want 1", idle); end
    tick();
    rst_n = 1'b1;
    tick();
    exp_id = 0; exp_flits = 0;
    push(21, 1, 2);
    tick();
    for (int i = 0; i < 2; i++) begin
      do_step(4'hF);
      s = staging;
      n_total++;
      if (s.full !== 1'b1 || s.dst !== 14'd21 || s.flit_idx !== 4'(i) || s.tail !== (i == 1) || s.pkt_id !== 8'd0) begin
        n_bad++;
        $display("FAIL after_rst%0d: got full=%0b dst=%0d idx=%0d tail=%0b id=%0d want 1 21 %0d %0b 0",
                 i, s.full, s.dst, s.flit_idx, s.tail, s.pkt_id, i, (i == 1));
      end
    end
    exp_id++; exp_flits += 2;
    n_total++; if (flit_cnt !== (STATS ? 32'd2 : 32'd0)) begin
      n_bad++; $display("FAIL flit_cnt_rst: got %0d want %0d", flit_cnt, STATS ? 2 : 0); end
  endtask

  task automatic test_pkt_id_wrap();
    staging_t s;
    do_reset();
    for (int i = 0; i < 257; i++) begin
      push(i % 100, i % 4, 0);
      tick();
      do_step(4'hF);
      s = staging;
      n_total++;
      if (s.full !== 1'b1 || s.tail !== 1'b1 || s.pkt_id !== 8'(i % 256)) begin
        n_bad++;
        $display("FAIL wrap%0d: got full=%0b tail=%0b id=%0d want 1 1 %0d", i, s.full, s.tail, s.pkt_id, i % 256);
      end
      if (i == 255) begin
        n_total++; if (flit_cnt !== (STATS ? 32'd256 : 32'd0)) begin
          n_bad++; $display("FAIL flit_cnt_256: got %0d want %0d", flit_cnt, STATS ? 256 : 0); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_pkt_id_wrap();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
